demux_pipe_1xn: RTL and testbench
=================================

// Module: demux_pipe_1xn
// PURPOSE
// - Parametrised, pipelined 1-to-N demultiplexer for the io_reg test designs.
// - Routes a DATA_W-bit word with a valid flag to one of N_OUT channels, chosen by sel.
// - Adds the following over the fixed-width registered demux trees:
//   - configurable pipeline depth;
//   - a global stall (en);
//   - hold/zero mode for non-selected channels;
//   - out-of-range select detection and a saturating error counter.
// PARAMETERS
// - N_OUT        512  number of output channels, >=2, need not be a power of 2
// - DATA_W       1    width of each data word / output channel
// - PIPE_STAGES  3    total latency in cycles, >=1 (PIPE_STAGES-1 delay stages + output reg)
// - HOLD_MODE    0    0: non-selected channels driven 0; 1: non-selected channels hold last value
// - SEL_W        $clog2(N_OUT), localparam (derived, not overridable)
// PORTS
// - clk      in   1             rising-edge clock
// - rst_n    in   1             asynchronous active-low reset
// - en       in   1             pipeline advance enable; 0 = stall
// - in_valid in   1             input word valid
// - in       in   DATA_W        input data
// - sel      in   SEL_W         destination channel index
// - err_clr  in   1             synchronous clear of err_cnt
// - out      out  N_OUT*DATA_W  channel k data at out[k*DATA_W +: DATA_W]
// - out_valid out N_OUT         one-hot (or zero) per-channel valid strobe
// - err      out  1             1-cycle pulse: an out-of-range sel reached the output stage
// - err_cnt  out  8             saturating count of out-of-range drops
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - all pipeline regs, out, out_valid, err and err_cnt go to 0 immediately;
//   - in-flight words are discarded. Release is synchronous to clk.
// - Accept: {in_valid, sel, in} is captured at a rising edge with en=1. in_valid=0 captures a bubble.
// - Latency: an item accepted at edge T appears on out/out_valid after edge T+PIPE_STAGES-1.
//   - This holds for an uninterrupted en=1; stalled cycles add latency 1:1.
//   - PIPE_STAGES=1: the decode register is the only stage.
// - Output stage, at each edge with en=1, for the item leaving the last delay stage:
//   - valid and sel<N_OUT:
//     - out_valid[sel] <= 1 and all other out_valid bits <= 0;
//     - channel sel data <= item data;
//     - other channels <= 0 (HOLD_MODE=0) or unchanged (HOLD_MODE=1).
//   - bubble: out_valid <= 0; channel data <= 0 (HOLD_MODE=0) or unchanged (HOLD_MODE=1).
//   - valid and sel>=N_OUT (possible only if N_OUT is not a power of 2):
//     - the item is dropped: out_valid <= 0, and data follows the bubble rule;
//     - err <= 1;
//     - err_cnt <= err_cnt+1, saturating at 255.
// - Stall (en=0):
//   - all delay stages hold their contents;
//   - out_valid <= 0 and err <= 0, so each item strobes exactly one cycle;
//   - channel data holds regardless of HOLD_MODE;
//   - no input is captured.
// - err_clr=1 at an edge: err_cnt <= 0, taking priority over a simultaneous increment.
//   The err pulse itself is still generated.
// - Back-to-back valid items with en=1 sustain one item per cycle.
//   Consecutive items to the same channel give out_valid[k] high on consecutive cycles.
// - out_valid never has more than one bit set.
// - No combinational path from any input to any output.
// TESTING
// - Reset mid-stream:
//   - N_OUT=512, PIPE_STAGES=3: drive 3 valid items, assert rst_n=0 between edges;
//   - required: all outputs 0 at once; after release, no out_valid from the discarded items.
// - Latency and routing:
//   - in=1, sel=9'd300, in_valid=1 at edge 0, then bubbles;
//   - required: out_valid[300]=1 and out[300]=1 after edge 2 only;
//   - one cycle later, out_valid=0 and out[300]=0 (HOLD_MODE=0).
// - Hold mode and throughput:
//   - HOLD_MODE=1, DATA_W=8, N_OUT=4: send 0xA5->ch1, 0x3C->ch2, 0xFF->ch1 back-to-back;
//   - required: out_valid one-hot 0010,0100,0010 on consecutive cycles;
//   - afterwards ch1=0xFF and ch2=0x3C hold indefinitely.
// - Stall:
//   - 2 items in flight, then en=0 for 4 cycles;
//   - required: no out_valid during the stall;
//   - items emerge in order, one cycle apart, 4 cycles later than unstalled.
// - Out of range:
//   - N_OUT=6: send sel=7 three times, then 253 more times;
//   - required: no out_valid; err pulses each time; err_cnt=3, then saturates at 255;
//   - err_clr coincident with an err pulse -> err_cnt=0.
// - Width corner:
//   - PIPE_STAGES=1, N_OUT=2, DATA_W=1;
//   - required: output on the same edge the item is captured;
//   - functionally equivalent to a registered 1x2 demux.

Source files
------------

// File: rtl/demux_pipe_1xn.sv
// -----------------------------------------------------------------------------
// demux_pipe_1xn
// Pipelined 1-to-N demultiplexer. A {in_valid, sel, in} item enters a chain of
// PIPE_STAGES-1 delay registers and is then decoded into a registered output
// stage. The output stage drives exactly one channel's data and valid strobe.
//
// Behaviour for channels that are not selected depends on HOLD_MODE:
//   0 - the channel's data is driven to zero
//   1 - the channel's data keeps its last value
//
// A select value >= N_OUT is dropped. It produces a one-cycle err pulse and
// bumps a saturating error counter.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         pipeline advance enable (0 = stall everything)
//   in_valid   input word valid
//   in         input data word, DATA_W bits
//   sel        destination channel index, SEL_W bits
//   err_clr    synchronous clear of err_cnt (wins over an increment)
//   out        channel k data at out[k*DATA_W +: DATA_W]
//   out_valid  per-channel valid strobe, at most one bit set
//   err        one-cycle pulse when an out-of-range item reaches the output
//   err_cnt    saturating count of out-of-range drops
// -----------------------------------------------------------------------------
module demux_pipe_1xn #(
  parameter  int N_OUT       = 512,
  parameter  int DATA_W      = 1,
  parameter  int PIPE_STAGES = 3,
  parameter  int HOLD_MODE   = 0,
  localparam int SEL_W       = $clog2(N_OUT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      err_clr,
  output logic [N_OUT*DATA_W-1:0]   out,
  output logic [N_OUT-1:0]          out_valid,
  output logic                      err,
  output logic [7:0]                err_cnt
);

  typedef struct packed {
    logic              valid;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } item_t;

  item_t in_item;
  item_t head;   // item presented to the output stage this cycle

  assign in_item = {in_valid, sel, in};

  // ---------------------------------------------------------------------------
  // Delay chain. With PIPE_STAGES=1 there is no delay register, and the output
  // stage decodes the input directly.
  // ---------------------------------------------------------------------------
  generate
    if (PIPE_STAGES > 1) begin : g_delay
      localparam int ND = PIPE_STAGES - 1;

      item_t stage_q [ND];
      item_t stage_d [ND];

      always_comb begin
        stage_d[0] = en ? in_item : stage_q[0];
        for (int i = 1; i < ND; i++) begin
          stage_d[i] = en ? stage_q[i-1] : stage_q[i];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < ND; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < ND; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign head = stage_q[ND-1];
    end else begin : g_nodelay
      assign head = in_item;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Range check. When N_OUT is a power of two, every select value is legal.
  // In that case no comparison is built.
  // ---------------------------------------------------------------------------
  logic in_range;

  generate
    if ((1 << SEL_W) == N_OUT) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      localparam logic [SEL_W:0] N_OUT_V = (SEL_W+1)'(N_OUT);
      assign in_range = ({1'b0, head.sel} < N_OUT_V);
    end
  endgenerate

  logic hit;
  assign hit = head.valid & in_range;

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [N_OUT*DATA_W-1:0] out_q, out_d;
  logic [N_OUT-1:0]        out_valid_q, out_valid_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  // Per-channel decode. While stalled, data holds in both modes.
  // Valid strobes drop to zero, so each item strobes for a single cycle.
  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
      logic match;
      assign match = hit && (head.sel == SEL_W'(gi));

      assign out_valid_d[gi] = en & match;

      assign out_d[gi*DATA_W +: DATA_W] =
        !en              ? out_q[gi*DATA_W +: DATA_W] :
        match            ? head.data :
        (HOLD_MODE != 0) ? out_q[gi*DATA_W +: DATA_W] :
                           {DATA_W{1'b0}};
    end
  endgenerate

  always_comb begin
    err_d     = en & head.valid & ~in_range;
    err_cnt_d = err_cnt_q;
    // A clear wins over an increment on the same edge.
    // The err pulse itself is still produced.
    if (err_clr) begin
      err_cnt_d = 8'd0;
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_demux_pipe_1xn.sv
// -----------------------------------------------------------------------------
// tb_demux_pipe_1xn
// Directed bench for demux_pipe_1xn, covering four parameterisations:
//   u_a : N_OUT=512, DATA_W=1, PIPE_STAGES=3, HOLD_MODE=0
//         (routing, latency, mid-stream reset, stall)
//   u_b : N_OUT=4,   DATA_W=8, PIPE_STAGES=3, HOLD_MODE=1
//         (hold mode, back-to-back throughput)
//   u_c : N_OUT=6,   DATA_W=4, PIPE_STAGES=2, HOLD_MODE=0
//         (out-of-range select, error counter)
//   u_d : N_OUT=2,   DATA_W=1, PIPE_STAGES=1, HOLD_MODE=0
//         (single-stage corner case)
//
// Inputs are driven 1 time unit after a rising edge.
// Outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_demux_pipe_1xn;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A ----------------
  logic         a_en, a_in_valid, a_err_clr, a_err;
  logic [0:0]   a_in;
  logic [8:0]   a_sel;
  logic [511:0] a_out, a_out_valid;
  logic [7:0]   a_err_cnt;

  demux_pipe_1xn #(
    .N_OUT(512), .DATA_W(1), .PIPE_STAGES(3), .HOLD_MODE(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .in_valid(a_in_valid),
    .in(a_in), .sel(a_sel), .err_clr(a_err_clr),
    .out(a_out), .out_valid(a_out_valid), .err(a_err), .err_cnt(a_err_cnt)
  );

  // ---------------- instance B ----------------
  logic        b_en, b_in_valid, b_err_clr, b_err;
  logic [7:0]  b_in;
  logic [1:0]  b_sel;
  logic [31:0] b_out;
  logic [3:0]  b_out_valid;
  logic [7:0]  b_err_cnt;

  demux_pipe_1xn #(
    .N_OUT(4), .DATA_W(8), .PIPE_STAGES(3), .HOLD_MODE(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .in_valid(b_in_valid),
    .in(b_in), .sel(b_sel), .err_clr(b_err_clr),
    .out(b_out), .out_valid(b_out_valid), .err(b_err), .err_cnt(b_err_cnt)
  );

  // ---------------- instance C ----------------
  logic        c_en, c_in_valid, c_err_clr, c_err;
  logic [3:0]  c_in;
  logic [2:0]  c_sel;
  logic [23:0] c_out;
  logic [5:0]  c_out_valid;
  logic [7:0]  c_err_cnt;

  demux_pipe_1xn #(
    .N_OUT(6), .DATA_W(4), .PIPE_STAGES(2), .HOLD_MODE(0)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .in_valid(c_in_valid),
    .in(c_in), .sel(c_sel), .err_clr(c_err_clr),
    .out(c_out), .out_valid(c_out_valid), .err(c_err), .err_cnt(c_err_cnt)
  );

  // ---------------- instance D ----------------
  logic       d_en, d_in_valid, d_err_clr, d_err;
  logic [0:0] d_in;
  logic [0:0] d_sel;
  logic [1:0] d_out, d_out_valid;
  logic [7:0] d_err_cnt;

  demux_pipe_1xn #(
    .N_OUT(2), .DATA_W(1), .PIPE_STAGES(1), .HOLD_MODE(0)
  ) u_d (
    .clk(clk), .rst_n(rst_n), .en(d_en), .in_valid(d_in_valid),
    .in(d_in), .sel(d_sel), .err_clr(d_err_clr),
    .out(d_out), .out_valid(d_out_valid), .err(d_err), .err_cnt(d_err_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (a_out_valid !== '0 || a_out !== '0 || a_err !== 1'b0 || a_err_cnt !== 8'd0)
      $display("FAIL reset_a: out_valid=%h out=%h err=%b err_cnt=%0d, required all 0",
               a_out_valid, a_out, a_err, a_err_cnt);
    if (a_out_valid !== '0 || a_out !== '0 || a_err !== 1'b0 || a_err_cnt !== 8'd0)
      n_fail++;
    n_tests++;
    if (b_out !== 32'h0 || b_out_valid !== 4'h0) begin
      $display("FAIL reset_b: out=%h out_valid=%b, required 0", b_out, b_out_valid);
      n_fail++;
    end
    n_tests++;
    if (c_err_cnt !== 8'd0 || c_err !== 1'b0) begin
      $display("FAIL reset_c: err=%b err_cnt=%0d, required 0", c_err, c_err_cnt);
      n_fail++;
    end
    n_tests++;
    if (d_out_valid !== 2'b00 || d_out !== 2'b00) begin
      $display("FAIL reset_d: out_valid=%b out=%b, required 00", d_out_valid, d_out);
      n_fail++;
    end
    rst_n = 1'b1;
    tick();
    $display("[TB] reset checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_latency_routing;
    logic [511:0] exp_v;
    exp_v = '0;
    exp_v[300] = 1'b1;
    a_en = 1'b1; a_in_valid = 1'b1; a_in = 1'b1; a_sel = 9'd300;
    tick();                                   // edge 0: capture
    a_in_valid = 1'b0; a_in = 1'b0; a_sel = 9'd0;
    n_tests++;
    if (a_out_valid !== '0) begin
      $display("FAIL lat_edge0: out_valid=%h, required 0", a_out_valid);
      n_fail++;
    end
    tick();                                   // edge 1
    n_tests++;
    if (a_out_valid !== '0) begin
      $display("FAIL lat_edge1: out_valid=%h, required 0", a_out_valid);
      n_fail++;
    end
    tick();                                   // edge 2: item appears
    n_tests++;
    if (a_out_valid !== exp_v) begin
      $display("FAIL lat_edge2_valid: out_valid=%h, required %h", a_out_valid, exp_v);
      n_fail++;
    end
    n_tests++;
    if (a_out !== exp_v) begin
      $display("FAIL lat_edge2_data: out=%h, required %h", a_out, exp_v);
      n_fail++;
    end
    tick();                                   // edge 3: bubble clears it
    n_tests++;
    if (a_out_valid !== '0 || a_out[300] !== 1'b0) begin
      $display("FAIL lat_edge3: out_valid=%h out[300]=%b, required 0/0",
               a_out_valid, a_out[300]);
      n_fail++;
    end
    $display("[TB] latency/routing sel=300 checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midstream;
    a_en = 1'b1; a_in_valid = 1'b1; a_in = 1'b1; a_sel = 9'd10;
    tick();
    a_sel = 9'd20;
    tick();
    a_sel = 9'd30;
    tick();                                   // first item now at the output
    a_in_valid = 1'b0;
    n_tests++;
    if (a_out_valid[10] !== 1'b1) begin
      $display("FAIL midrst_pre: out_valid[10]=%b, required 1", a_out_valid[10]);
      n_fail++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (a_out_valid !== '0 || a_out !== '0 || a_err !== 1'b0) begin
      $display("FAIL midrst_async: out_valid=%h out=%h err=%b, required 0",
               a_out_valid, a_out, a_err);
      n_fail++;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (a_out_valid !== '0) begin
        $display("FAIL midrst_after%0d: out_valid=%h, required 0", i, a_out_valid);
        n_fail++;
      end
    end
    $display("[TB] mid-stream reset checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall;
    logic [511:0] exp5, exp6;
    exp5 = '0; exp5[5] = 1'b1;
    exp6 = '0; exp6[6] = 1'b1;
    a_en = 1'b1; a_in_valid = 1'b1; a_in = 1'b1; a_sel = 9'd5;
    tick();                                   // edge 0
    a_sel = 9'd6;
    tick();                                   // edge 1
    a_in_valid = 1'b0; a_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();                                 // edges 2..5 stalled
      n_tests++;
      if (a_out_valid !== '0) begin
        $display("FAIL stall_cyc%0d: out_valid=%h, required 0", i, a_out_valid);
        n_fail++;
      end
    end
    a_en = 1'b1;
    tick();                                   // edge 6
    n_tests++;
    if (a_out_valid !== exp5 || a_out !== exp5) begin
      $display("FAIL stall_first: out_valid=%h out=%h, required %h", a_out_valid, a_out, exp5);
      n_fail++;
    end
    tick();                                   // edge 7
    n_tests++;
    if (a_out_valid !== exp6 || a_out !== exp6) begin
      $display("FAIL stall_second: out_valid=%h out=%h, required %h", a_out_valid, a_out, exp6);
      n_fail++;
    end
    tick();
    n_tests++;
    if (a_out_valid !== '0) begin
      $display("FAIL stall_drain: out_valid=%h, required 0", a_out_valid);
      n_fail++;
    end
    $display("[TB] stall checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_hold_throughput;
    b_en = 1'b1; b_in_valid = 1'b1;
    b_in = 8'hA5; b_sel = 2'd1; tick();       // edge 0
    b_in = 8'h3C; b_sel = 2'd2; tick();       // edge 1
    b_in = 8'hFF; b_sel = 2'd1; tick();       // edge 2: A5 out
    b_in_valid = 1'b0; b_in = 8'h00; b_sel = 2'd0;
    n_tests++;
    if (b_out_valid !== 4'b0010 || b_out !== 32'h0000_A500) begin
      $display("FAIL hold_b2b0: out_valid=%b out=%h, required 0010 0000a500", b_out_valid, b_out);
      n_fail++;
    end
    tick();                                   // edge 3: 3C out
    n_tests++;
    if (b_out_valid !== 4'b0100 || b_out !== 32'h003C_A500) begin
      $display("FAIL hold_b2b1: out_valid=%b out=%h, required 0100 003ca500", b_out_valid, b_out);
      n_fail++;
    end
    tick();                                   // edge 4: FF out
    n_tests++;
    if (b_out_valid !== 4'b0010 || b_out !== 32'h003C_FF00) begin
      $display("FAIL hold_b2b2: out_valid=%b out=%h, required 0010 003cff00", b_out_valid, b_out);
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (b_out_valid !== 4'b0000 || b_out !== 32'h003C_FF00) begin
        $display("FAIL hold_keep%0d: out_valid=%b out=%h, required 0000 003cff00",
                 i, b_out_valid, b_out);
        n_fail++;
      end
    end
    $display("[TB] hold mode / throughput checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_out_of_range;
    c_en = 1'b1; c_in_valid = 1'b1; c_sel = 3'd7; c_in = 4'hF;
    for (int i = 0; i < 256; i++) begin
      tick();                                 // drop i-1 reaches output after edge i
      if (i >= 1) begin
        n_tests++;
        if (c_err !== 1'b1 || c_out_valid !== 6'b0 || c_out !== 24'h0 ||
            c_err_cnt !== 8'(i)) begin
          $display("FAIL oor_drop%0d: err=%b out_valid=%b out=%h err_cnt=%0d, required 1 0 0 %0d",
                   i, c_err, c_out_valid, c_out, c_err_cnt, i);
          n_fail++;
        end
      end
    end
    c_in_valid = 1'b0;
    tick();                                   // 256th drop: counter saturated
    n_tests++;
    if (c_err !== 1'b1 || c_err_cnt !== 8'd255) begin
      $display("FAIL oor_sat: err=%b err_cnt=%0d, required 1 255", c_err, c_err_cnt);
      n_fail++;
    end
    tick();
    n_tests++;
    if (c_err !== 1'b0 || c_err_cnt !== 8'd255) begin
      $display("FAIL oor_idle: err=%b err_cnt=%0d, required 0 255", c_err, c_err_cnt);
      n_fail++;
    end
    c_in_valid = 1'b1;
    tick();                                   // capture one more bad item
    c_in_valid = 1'b0; c_err_clr = 1'b1;
    tick();                                   // err pulse and clear on the same edge
    c_err_clr = 1'b0;
    n_tests++;
    if (c_err !== 1'b1 || c_err_cnt !== 8'd0) begin
      $display("FAIL oor_clr: err=%b err_cnt=%0d, required 1 0", c_err, c_err_cnt);
      n_fail++;
    end
    tick();
    n_tests++;
    if (c_err !== 1'b0 || c_err_cnt !== 8'd0) begin
      $display("FAIL oor_clr_after: err=%b err_cnt=%0d, required 0 0", c_err, c_err_cnt);
      n_fail++;
    end
    c_in_valid = 1'b1; c_sel = 3'd5; c_in = 4'hA;
    tick();
    c_in_valid = 1'b0;
    tick();
    n_tests++;
    if (c_out_valid !== 6'b100000 || c_out !== 24'hA0_0000 || c_err !== 1'b0) begin
      $display("FAIL oor_inrange: out_valid=%b out=%h err=%b, required 100000 a00000 0",
               c_out_valid, c_out, c_err);
      n_fail++;
    end
    $display("[TB] out-of-range / err_cnt checked");
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_width_corner;
    d_en = 1'b1; d_in_valid = 1'b1; d_sel = 1'b1; d_in = 1'b1;
    tick();
    n_tests++;
    if (d_out_valid !== 2'b10 || d_out !== 2'b10) begin
      $display("FAIL corner_ch1: out_valid=%b out=%b, required 10 10", d_out_valid, d_out);
      n_fail++;
    end
    d_sel = 1'b0;
    tick();
    n_tests++;
    if (d_out_valid !== 2'b01 || d_out !== 2'b01) begin
      $display("FAIL corner_ch0: out_valid=%b out=%b, required 01 01", d_out_valid, d_out);
      n_fail++;
    end
    d_sel = 1'b1; d_in = 1'b0;
    tick();
    n_tests++;
    if (d_out_valid !== 2'b10 || d_out !== 2'b00) begin
      $display("FAIL corner_zero: out_valid=%b out=%b, required 10 00", d_out_valid, d_out);
      n_fail++;
    end
    d_in_valid = 1'b0;
    tick();
    n_tests++;
    if (d_out_valid !== 2'b00 || d_out !== 2'b00) begin
      $display("FAIL corner_bubble: out_valid=%b out=%b, required 00 00", d_out_valid, d_out);
      n_fail++;
    end
    $display("[TB] PIPE_STAGES=1 corner checked");
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    a_en = 1'b0; a_in_valid = 1'b0; a_in = '0; a_sel = '0; a_err_clr = 1'b0;
    b_en = 1'b0; b_in_valid = 1'b0; b_in = '0; b_sel = '0; b_err_clr = 1'b0;
    c_en = 1'b0; c_in_valid = 1'b0; c_in = '0; c_sel = '0; c_err_clr = 1'b0;
    d_en = 1'b0; d_in_valid = 1'b0; d_in = '0; d_sel = '0; d_err_clr = 1'b0;

    test_reset();
    test_latency_routing();
    test_reset_midstream();
    test_stall();
    test_hold_throughput();
    test_out_of_range();
    test_width_corner();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
